// File: rtl/wb_stage_mc.sv
// wb_stage_mc: multi-source MIPS write-back stage.
// Picks one of four result sources, registers the register-file write, suppresses
// writes to r0, and stalls the pipeline while a DSP result is outstanding. The DSP
// wait gives up after TIMEOUT_CYC stalled cycles.
// Optional feature macro: WB_LOAD_EXT_EN adds byte/half load alignment and
// sign/zero extension on the memory source; without it Memory_Data passes straight through.
module wb_stage_mc #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Valid_in,
   input  logic              Flush,
   input  logic              Reg_Write_En_in,
   input  logic [ADDR_W-1:0] Addr_Write_Reg_in,
   input  logic [1:0]        WB_Sel,
   input  logic [DATA_W-1:0] ALU_Data,
   input  logic [DATA_W-1:0] Memory_Data,
   input  logic [DATA_W-1:0] Link_Data,
   input  logic [DATA_W-1:0] Dsp_Data,
   input  logic              Dsp_Ready,
`ifdef WB_LOAD_EXT_EN
   input  logic [1:0]        Load_Size,
   input  logic              Load_Signed,
   input  logic [1:0]        Byte_Off,
`endif
   output logic              Stall_out,
   output logic              Dsp_Timeout,
   output logic              Reg_Write_En_out,
   output logic [ADDR_W-1:0] Addr_Write_Reg_out,
   output logic [DATA_W-1:0] Reg_Write_Data_out
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [0:0] {
      S_IDLE     = 1'b0,
      S_WAIT_DSP = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   wait_addr_q, wait_addr_d;
   logic                en_q, en_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                timeout_q, timeout_d;
   logic                stall;
   logic                dsp_wait_start;
   logic [DATA_W-1:0]   mem_res;
   logic [DATA_W-1:0]   sel_data;

`ifdef WB_LOAD_EXT_EN
   logic [DATA_W-1:0]   mem_shift;

   // Align the addressed byte/half to bit 0, then sign or zero extend it
   always_comb begin
      mem_shift = Memory_Data;
      mem_res   = Memory_Data;
      case (Load_Size)
         2'd0: begin
            mem_shift = Memory_Data >> {Byte_Off, 3'b000};
            mem_res   = Load_Signed ? {{(DATA_W-8){mem_shift[7]}}, mem_shift[7:0]}
                                    : {{(DATA_W-8){1'b0}}, mem_shift[7:0]};
         end
         2'd1: begin
            mem_shift = Byte_Off[1] ? (Memory_Data >> 16) : Memory_Data;
            mem_res   = Load_Signed ? {{(DATA_W-16){mem_shift[15]}}, mem_shift[15:0]}
                                    : {{(DATA_W-16){1'b0}}, mem_shift[15:0]};
         end
         default: begin
            mem_shift = Memory_Data;
            mem_res   = Memory_Data;
         end
      endcase
   end
`else
   // Word loads only: memory data is written back unmodified
   always_comb begin
      mem_res = Memory_Data;
   end
`endif

   // Result source multiplexer
   always_comb begin
      sel_data = ALU_Data;
      case (WB_Sel)
         2'd0:    sel_data = ALU_Data;
         2'd1:    sel_data = mem_res;
         2'd2:    sel_data = Link_Data;
         default: sel_data = Dsp_Data;
      endcase
   end

   // A writing DSP instruction whose result is not ready yet must wait
   always_comb begin
      dsp_wait_start = Valid_in & Reg_Write_En_in & (WB_Sel == 2'd3) & ~Dsp_Ready & ~Flush;
   end

   // Next-state logic for the FSM, timeout counter and registered write port
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wait_addr_d = wait_addr_q;
      en_d        = 1'b0;
      addr_d      = addr_q;
      data_d      = data_q;
      timeout_d   = 1'b0;
      stall       = 1'b0;
      if (state_q == S_IDLE) begin
         addr_d = Addr_Write_Reg_in;
         data_d = sel_data;
         if (dsp_wait_start) begin
            // The entry cycle counts as the first stalled cycle of the wait
            stall       = 1'b1;
            state_d     = S_WAIT_DSP;
            cnt_d       = CNT_ONE;
            wait_addr_d = Addr_Write_Reg_in;
         end else begin
            en_d = Valid_in & Reg_Write_En_in & (Addr_Write_Reg_in != '0) & ~Flush;
         end
      end else begin
         stall = 1'b1;
         if (Flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end else if (Dsp_Ready) begin
            en_d    = (wait_addr_q != '0);
            addr_d  = wait_addr_q;
            data_d  = Dsp_Data;
            state_d = S_IDLE;
            cnt_d   = '0;
         end else if (cnt_q >= CNT_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   // State and output registers; reset drops any pending DSP wait immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wait_addr_q <= '0;
         en_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wait_addr_q <= wait_addr_d;
         en_q        <= en_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         timeout_q   <= timeout_d;
      end
   end

   // Stall is combinational so the stage can hold upstream in the entry cycle; reset masks it
   always_comb begin
      Stall_out          = stall & reset;
      Dsp_Timeout        = timeout_q;
      Reg_Write_En_out   = en_q;
      Addr_Write_Reg_out = addr_q;
      Reg_Write_Data_out = data_q;
   end

endmodule
